rng_byte_source: RTL and testbench



---
 rtl/rng_pkg.sv | 19 +
 rtl/rng_fifo.sv | 62 ++++++
 rtl/rng_byte_source.sv | 165 ++++++++++++++++
 tb/tb_rng_byte_source.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and widths for the RNG byte source: transmit and von Neumann state
// encodings plus the byte width.
package rng_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } tx_state_t;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } vn_state_t;

endpackage

// File: rtl/rng_fifo.sv
// Single-clock byte FIFO. Head data is presented combinationally, and a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module rng_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full_c  = (r_level == LVL_W'(DEPTH));
    assign o_empty_c = (r_level == '0);
    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    assign w_do_pop  = i_pop && !o_empty_c;
    assign w_do_push = i_push && (!o_full_c || w_do_pop);

    // Storage is deliberately not reset; pointers and level define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rng_byte_source.sv
// Conditions the ring-oscillator bit (sync, decimate, von Neumann debias), packs it
// LSB-first into bytes, buffers them and feeds the UART start/busy handshake.
module rng_byte_source
    import rng_pkg::*;
#(
    parameter  int unsigned DECIM      = 8,
    parameter  bit          VN_ENABLE  = 1'b1,
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_raw_bit,
    input  logic              i_tx_busy,
    output logic              o_tx_start,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic [31:0]       o_disp_word,
    output logic              o_overflow,
    output logic [LVL_W-1:0]  o_fifo_level
);

    localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic              r_sync1;
    logic              r_sync2;
    logic [DEC_W-1:0]  r_dec_cnt;
    vn_state_t         r_vn_state;
    logic              r_vn_a;
    logic [BYTE_W-1:0] r_sr;
    logic [2:0]        r_bit_cnt;
    logic              r_overflow;
    logic [31:0]       r_disp_word;
    tx_state_t         r_tx_state;
    logic              r_tx_start;
    logic [BYTE_W-1:0] r_tx_data;

    logic              w_strobe;
    logic              w_emit;
    logic              w_emit_bit;
    vn_state_t         w_vn_next;
    logic [BYTE_W-1:0] w_byte;
    logic              w_byte_done;
    logic              w_push_ok;
    logic              w_pop;
    logic              w_tx_start_d;
    tx_state_t         w_tx_next;
    logic [BYTE_W-1:0] w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [LVL_W-1:0]  w_fifo_level;

    assign w_strobe    = (r_dec_cnt == DEC_W'(DECIM - 1));
    assign w_byte      = {w_emit_bit, r_sr[BYTE_W-1:1]};
    assign w_byte_done = w_emit && (r_bit_cnt == 3'd7);
    assign w_push_ok   = w_byte_done && (!w_fifo_full || w_pop);

    // Von Neumann pairing: emit the first sample of an unequal pair.
    always_comb begin
        w_emit     = 1'b0;
        w_emit_bit = r_sync2;
        w_vn_next  = r_vn_state;
        if (w_strobe) begin
            if (!VN_ENABLE) begin
                w_emit = 1'b1;
            end else if (r_vn_state == FIRST) begin
                w_vn_next = SECOND;
            end else begin
                w_vn_next  = FIRST;
                w_emit     = (r_vn_a != r_sync2);
                w_emit_bit = r_vn_a;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_dec_cnt   <= '0;
            r_vn_state  <= FIRST;
            r_vn_a      <= 1'b0;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_disp_word <= '0;
        end else begin
            r_sync1    <= i_raw_bit;
            r_sync2    <= r_sync1;
            r_dec_cnt  <= w_strobe ? '0 : r_dec_cnt + DEC_W'(1);
            r_vn_state <= w_vn_next;
            if (w_strobe && (r_vn_state == FIRST)) begin
                r_vn_a <= r_sync2;
            end
            if (w_emit) begin
                r_sr      <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_push_ok) begin
                r_disp_word <= {r_disp_word[23:0], w_byte};
            end
        end
    end

    rng_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_push    (w_byte_done),
        .i_pop     (w_pop),
        .i_wdata   (w_byte),
        .o_rdata_c (w_fifo_head),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty),
        .o_level   (w_fifo_level)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            IDLE:    if (!w_fifo_empty && !i_tx_busy) w_tx_next = SEND;
            SEND:    w_tx_next = HOLD;
            HOLD:    w_tx_next = WAIT;
            WAIT:    if (!i_tx_busy) w_tx_next = IDLE;
            default: w_tx_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop        = (r_tx_state == IDLE) && !w_fifo_empty && !i_tx_busy;
        w_tx_start_d = (w_tx_next == SEND);
    end

    // tx_start is registered so it coincides with the SEND state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_tx_start_d;
            if (w_pop) begin
                r_tx_data <= w_fifo_head;
            end
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_disp_word  = r_disp_word;
    assign o_overflow   = r_overflow;
    assign o_fifo_level = w_fifo_level;

endmodule

// File: tb/tb_rng_byte_source.sv
// Scoreboard bench for rng_byte_source: directed raw-bit streams aligned to the
// decimation strobe, expected bytes queued and checked by a tx_start monitor.
module tb_rng_byte_source;

    localparam int unsigned DECIM      = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned LVL_W      = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             raw_bit = 1'b0;
    logic             tx_busy = 1'b0;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [31:0]      disp_word;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_tx = 0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;
    logic [7:0] exp_q[$];

    rng_byte_source #(
        .DECIM      (DECIM),
        .VN_ENABLE  (1'b1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_raw_bit    (raw_bit),
        .i_tx_busy    (tx_busy),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_disp_word  (disp_word),
        .o_overflow   (overflow),
        .o_fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for a few cycles after each start, or held by the test.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) busy_cnt = 3;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = force_busy || (busy_cnt != 0);
        end
    end

    // Monitor: every tx_start must match the oldest expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                n_tx++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got tx_start with data 0x%02h, expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", {24'h0, tx_data}, {24'h0, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the bench on a negedge with the decimator phase known.
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        raw_bit = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic send_sample(input logic b);
        raw_bit = b;
        repeat (DECIM) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        send_sample(b);
        send_sample(~b);
    endtask

    // drop_busy releases the transmitter so its pop lands on the completing edge.
    task automatic send_byte(input logic [7:0] v, input bit drop_busy);
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && drop_busy) begin
                send_sample(v[7]);
                raw_bit = ~v[7];
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1 force_busy = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                send_bit(v[i]);
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && fifo_level == '0 && !tx_busy) break;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int  tx0;
        bit  found;

        // Reset values, then a stuck-at-1 source for 10000 cycles.
        do_reset();
        check("rst_tx_start", {31'h0, tx_start}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'd0);
        check("rst_disp", disp_word, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        raw_bit = 1'b1;
        repeat (10000) @(negedge clk);
        check("stuck_disp", disp_word, 32'd0);
        check("stuck_level", 32'(fifo_level), 32'd0);
        check("stuck_tx", 32'(n_tx), 32'd0);

        // Alternating pairs (1,0),(0,1) give 0x55 twice.
        do_reset();
        force_busy = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b0);
        check("pat_disp", disp_word, 32'h0000_5555);
        check("pat_level", 32'(fifo_level), 32'd2);
        tx0 = n_tx;
        force_busy = 1'b0;
        wait_drain();
        check("pat_tx_count", 32'(n_tx - tx0), 32'd2);

        // Overflow: 17 bytes into a 16-deep FIFO, byte 17 dropped.
        do_reset();
        force_busy = 1'b1;
        for (int k = 1; k <= 16; k++) exp_q.push_back(8'(k));
        for (int k = 1; k <= 17; k++) send_byte(8'(k), 1'b0);
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_flag", {31'h0, overflow}, 32'd1);
        check("ovf_disp", disp_word, 32'h0D0E_0F10);
        tx0 = n_tx;
        force_busy = 1'b0;
        wait_drain();
        check("ovf_tx_count", 32'(n_tx - tx0), 32'd16);
        check("ovf_level_after", 32'(fifo_level), 32'd0);
        check("ovf_sticky", {31'h0, overflow}, 32'd1);

        // Full FIFO, byte completes on the same edge as the IDLE pop.
        do_reset();
        force_busy = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back(8'hA0 + 8'(k));
        exp_q.push_back(8'h5A);
        for (int k = 0; k < 16; k++) send_byte(8'hA0 + 8'(k), 1'b0);
        check("full_level_pre", 32'(fifo_level), 32'd16);
        tx0 = n_tx;
        send_byte(8'h5A, 1'b1);
        check("full_pop_level", 32'(fifo_level), 32'd16);
        check("full_pop_ovf", {31'h0, overflow}, 32'd0);
        check("full_pop_disp", disp_word, 32'hADAE_AF5A);
        wait_drain();
        check("full_tx_count", 32'(n_tx - tx0), 32'd17);
        check("full_ovf_after", {31'h0, overflow}, 32'd0);

        // Reset after 5 emitted bits discards the partial byte.
        do_reset();
        force_busy = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        tx0 = n_tx;
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b0);
        wait_drain();
        check("midrst_disp", disp_word, 32'h0000_00A3);
        check("midrst_tx_count", 32'(n_tx - tx0), 32'd1);

        // Reset during SEND clears the FIFO and suppresses further starts.
        do_reset();
        force_busy = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        check("send_rst_level_pre", 32'(fifo_level), 32'd2);
        tx0 = n_tx;
        force_busy = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_start) begin
                found = 1'b1;
                break;
            end
        end
        check("send_seen", {31'h0, found}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        check("send_rst_start", {31'h0, tx_start}, 32'd0);
        check("send_rst_level", 32'(fifo_level), 32'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("send_rst_tx_count", 32'(n_tx - tx0), 32'd1);

        // Display shift register keeps the last four accepted bytes.
        do_reset();
        force_busy = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("disp_four", disp_word, 32'h1122_3344);
        send_byte(8'h55, 1'b0);
        check("disp_five", disp_word, 32'h2233_4455);
        force_busy = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
